fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch front end. Issues sequential word requests to the
//   instruction memory, buffers in-order responses in a small fetch queue
//   and presents the head entry to decode. A redirect from decode flushes
//   the queue, reloads the fetch PC and squashes responses still in flight.
//
// Parameters
//   RESET_PC  PC loaded on reset
//   FQ_DEPTH  fetch-queue entries and cap on outstanding requests (2 or 4)
//
// Optional feature macro
//   FETCH_BYPASS_EN  when defined, a live response arriving while the queue
//                    is empty is forwarded combinationally to decode and is
//                    queued only if decode does not take it.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   imem_req/addr       request valid / word byte address (= fetch PC)
//   imem_gnt            request accepted this cycle
//   imem_rvalid/rdata   in-order response valid / instruction word
//   id_stalls_if        decode cannot accept this cycle
//   sel_br/br_target    redirect from decode and its target PC
//   ins/ins_is_nop      instruction to decode / bubble flag
//   next_pc             PC of presented instruction + 4
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

module fetch_stage #(
  parameter logic [`DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int                     FQ_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [`DATA_WIDTH-1:0] imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [`INS_WIDTH-1:0]  imem_rdata,
  input  logic                   id_stalls_if,
  input  logic                   sel_br,
  input  logic [`DATA_WIDTH-1:0] br_target,
  output logic [`INS_WIDTH-1:0]  ins,
  output logic                   ins_is_nop,
  output logic [`DATA_WIDTH-1:0] next_pc
);

  localparam int DW = `DATA_WIDTH;
  localparam int IW = `INS_WIDTH;
  localparam int PW = (FQ_DEPTH > 2) ? 2 : 1;  // queue pointer width
  localparam int CW = PW + 1;                  // occupancy / outstanding width
  localparam int SW = CW + 2;                  // squash counter, room for back-to-back redirects
  localparam logic [CW:0]   DEPTH_L = FQ_DEPTH[CW:0];
  localparam logic [DW-1:0] PC_STEP = DW'(4);

  // Registered state
  logic [DW-1:0] fetch_pc_q, fetch_pc_d;
  logic [DW-1:0] resp_pc_q, resp_pc_d;       // PC of the next live response
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [SW-1:0] squash_q, squash_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [IW-1:0] ins_mem_q [FQ_DEPTH];
  logic [DW-1:0] npc_mem_q [FQ_DEPTH];

  // Combinational helpers
  logic          q_empty_s;
  logic          cap_ok_s;
  logic          grant_s;
  logic          rsp_live_s;
  logic          rsp_squash_s;
  logic          byp_s;
  logic          accept_s;
  logic          pop_s;
  logic          push_s;
  logic [CW:0]   inflight_sum_s;

  assign q_empty_s      = (count_q == {CW{1'b0}});
  assign inflight_sum_s = {1'b0, outstanding_q} + {1'b0, count_q};
  assign cap_ok_s       = (inflight_sum_s < DEPTH_L);

  assign imem_req  = ~reset & ~sel_br & cap_ok_s;
  assign imem_addr = fetch_pc_q;
  assign grant_s   = imem_req & imem_gnt;

  // A response is live only when no squashed responses are still ahead of it.
  assign rsp_live_s   = imem_rvalid & (squash_q == {SW{1'b0}});
  assign rsp_squash_s = imem_rvalid & (squash_q != {SW{1'b0}});

`ifdef FETCH_BYPASS_EN
  assign byp_s = rsp_live_s & q_empty_s;
`else
  assign byp_s = 1'b0;
`endif

  // Decode-facing outputs: head entry, optional bypass, or bubble.
  always_comb begin
    ins        = {IW{1'b0}};
    next_pc    = {DW{1'b0}};
    ins_is_nop = 1'b1;
    if (reset) begin
      ins        = {IW{1'b0}};
      next_pc    = {DW{1'b0}};
      ins_is_nop = 1'b1;
    end else if (!q_empty_s) begin
      ins        = ins_mem_q[head_q];
      next_pc    = npc_mem_q[head_q];
      ins_is_nop = 1'b0;
    end
`ifdef FETCH_BYPASS_EN
    else if (byp_s) begin
      ins        = imem_rdata;
      next_pc    = resp_pc_q + PC_STEP;
      ins_is_nop = 1'b0;
    end
`endif
    else begin
      ins        = {IW{1'b0}};
      next_pc    = {DW{1'b0}};
      ins_is_nop = 1'b1;
    end
  end

  assign accept_s = ~ins_is_nop & ~id_stalls_if;
  assign pop_s    = accept_s & ~q_empty_s;
  // A response arriving with a redirect is dropped; a bypassed one taken by
  // decode never needs a queue slot.
  assign push_s   = rsp_live_s & ~sel_br & ~(byp_s & accept_s);

  // Next-state for PCs, request accounting and squash counter.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    squash_d      = squash_q;
    if (sel_br) begin
      fetch_pc_d    = br_target;
      resp_pc_d     = br_target;
      outstanding_d = {CW{1'b0}};
      // Everything still in flight becomes squashed, minus a response that
      // lands this very cycle (it is already being thrown away).
      squash_d      = squash_q + SW'(outstanding_q) - SW'(imem_rvalid);
    end else begin
      if (grant_s) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (rsp_live_s) begin
        resp_pc_d = resp_pc_q + PC_STEP;
      end else begin
        resp_pc_d = resp_pc_q;
      end
      case ({grant_s, rsp_live_s})
        2'b10:   outstanding_d = outstanding_q + CW'(1);
        2'b01:   outstanding_d = outstanding_q - CW'(1);
        default: outstanding_d = outstanding_q;
      endcase
      if (rsp_squash_s) begin
        squash_d = squash_q - SW'(1);
      end else begin
        squash_d = squash_q;
      end
    end
  end

  // Next-state for queue pointers and occupancy.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (sel_br) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (pop_s) begin
        head_d = head_q + PW'(1);
      end else begin
        head_d = head_q;
      end
      if (push_s) begin
        tail_d = tail_q + PW'(1);
      end else begin
        tail_d = tail_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= {CW{1'b0}};
      squash_q      <= {SW{1'b0}};
      count_q       <= {CW{1'b0}};
      head_q        <= {PW{1'b0}};
      tail_q        <= {PW{1'b0}};
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      squash_q      <= squash_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  // Queue storage: each entry holds {instruction, pc + 4}.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        ins_mem_q[i] <= {IW{1'b0}};
        npc_mem_q[i] <= {DW{1'b0}};
      end
    end else if (push_s) begin
      ins_mem_q[tail_q] <= imem_rdata;
      npc_mem_q[tail_q] <= resp_pc_q + PC_STEP;
    end else begin
      ins_mem_q[tail_q] <= ins_mem_q[tail_q];
      npc_mem_q[tail_q] <= npc_mem_q[tail_q];
    end
  end

endmodule
